// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state type and parameter limits for the SRAM responder
// Contents:
//   sram_state_e   CLEAR (post-reset memory fill) / READY (accesses serviced)
//   LATENCY_MIN/MAX, WR_LAG_MIN/MAX  legal ranges of the responder timing parameters
//   CNT_W          width of the access statistics counters
package sram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } sram_state_e;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 8;
  localparam int WR_LAG_MIN  = 0;
  localparam int WR_LAG_MAX  = 1;
  localparam int CNT_W       = 32;

endpackage

// File: rtl/sram_dp_mem.sv
// rtl/sram_dp_mem.sv - simple dual-port memory, one write port and one registered read port
// Ports:
//   clk, rst   clock; synchronous active-high reset (clears only the read register)
//   we, waddr, wdata   write port, committed at the clock edge
//   re, raddr          read port; rdata is loaded at the edge, 0 when re=0
//   byp_en, byp_data   load byp_data instead of the array word (caller-side forwarding)
//   rdata              registered read data
module sram_dp_mem #(
  parameter int aw = 19,
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  logic [dw-1:0] wdata,
  input  logic          re,
  input  logic [aw-1:0] raddr,
  input  logic          byp_en,
  input  logic [dw-1:0] byp_data,
  output logic [dw-1:0] rdata
);

  logic [dw-1:0] mem [2**aw];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register doubles as the first data stage, so it idles at 0
  // rather than holding stale data between reads.
  always_ff @(posedge clk) begin
    if (rst || !re)  rdata <= '0;
    else if (byp_en) rdata <= byp_data;
    else             rdata <= mem[raddr];
  end

endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - emulation of an asynchronous SRAM device behind the SRAM phy bus
// Optional feature macro: SRAM_RESPONDER_STATS_EN (adds rd_count / wr_count)
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   sram_addr     word address
//   sram_ce_n     chip enable, active low (a sampled edge with ce_n=0 is an access)
//   sram_oe_n     output enable, active low (read when we_n=1)
//   sram_we_n     write enable, active low
//   sram_dat_wr   write data, valid wr_lag cycles after the write strobe
//   sram_dat_rd   read data, 0 whenever rd_drive=0
//   rd_drive      read data is being driven this cycle
//   ready         post-reset clear has finished
//   err_early     sticky: an access was attempted while ready=0
//   rd_count, wr_count   saturating counts of serviced reads / writes (stats build only)
module sram_responder
  import sram_pkg::*;
#(
  parameter int            aw      = 19,
  parameter int            dw      = 8,
  parameter int            latency = 1,
  parameter int            wr_lag  = 1,
  parameter logic [dw-1:0] fill    = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [aw-1:0] sram_addr,
  input  logic          sram_ce_n,
  input  logic          sram_oe_n,
  input  logic          sram_we_n,
  input  logic [dw-1:0] sram_dat_wr,
  output logic [dw-1:0] sram_dat_rd,
  output logic          rd_drive,
  output logic          ready,
  output logic          err_early
`ifdef SRAM_RESPONDER_STATS_EN
  ,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
`endif
);

  // Out-of-range parameters are pulled back into the supported range.
  localparam int lat_c = (latency < LATENCY_MIN) ? LATENCY_MIN :
                         (latency > LATENCY_MAX) ? LATENCY_MAX : latency;
  localparam int lag_c = (wr_lag < WR_LAG_MIN) ? WR_LAG_MIN :
                         (wr_lag > WR_LAG_MAX) ? WR_LAG_MAX : wr_lag;

  sram_state_e   state_q, state_d;
  logic [aw-1:0] clr_ptr_q;
  logic          is_ready;

  logic          mem_we;
  logic [aw-1:0] mem_waddr;
  logic [dw-1:0] mem_wdata;
  logic [dw-1:0] mem_rdata;

  logic          acc, wr_fire, rd_fire;
  logic          commit_en;
  logic [aw-1:0] commit_addr;
  logic [dw-1:0] commit_data;
  logic          byp_en;
  logic          mem_v_q;
  logic          err_early_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) clr_ptr_q <= clr_ptr_q + aw'(1);
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && clr_ptr_q == {aw{1'b1}}) state_d = READY;
  end

  // ---------------- FSM: outputs ----------------
  // During CLEAR the write port belongs to the fill sequencer; bus writes are
  // only possible in READY.
  always_comb begin
    is_ready  = (state_q == READY);
    mem_we    = commit_en && !rst;
    mem_waddr = commit_addr;
    mem_wdata = commit_data;
    if (state_q == CLEAR) begin
      mem_we    = !rst;
      mem_waddr = clr_ptr_q;
      mem_wdata = fill;
    end
  end

  assign ready = is_ready;

  // ---------------- bus decode ----------------
  assign acc     = !sram_ce_n;
  assign wr_fire = is_ready && acc && !sram_we_n;
  assign rd_fire = is_ready && acc && sram_we_n && !sram_oe_n;

  always_ff @(posedge clk) begin
    if (rst)                 err_early_q <= 1'b0;
    else if (!is_ready && acc) err_early_q <= 1'b1;
  end

  assign err_early = err_early_q;

  // ---------------- write commit ----------------
  generate
    if (lag_c == 0) begin : g_lag0
      assign commit_en   = wr_fire;
      assign commit_addr = sram_addr;
      assign commit_data = sram_dat_wr;
    end else begin : g_lag1
      // Address is captured at the strobe; data arrives and commits one edge later.
      logic          pend_v_q;
      logic [aw-1:0] pend_addr_q;

      always_ff @(posedge clk) begin
        if (rst) pend_v_q <= 1'b0;
        else     pend_v_q <= wr_fire;
        pend_addr_q <= sram_addr;
      end

      assign commit_en   = pend_v_q;
      assign commit_addr = pend_addr_q;
      assign commit_data = sram_dat_wr;
    end
  endgenerate

  // A read sampled at the edge that commits a write to the same word returns
  // the new data (write-first); this also covers the pending-write case.
  assign byp_en = commit_en && (commit_addr == sram_addr);

  sram_dp_mem #(
    .aw(aw),
    .dw(dw)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .re      (rd_fire),
    .raddr   (sram_addr),
    .byp_en  (byp_en),
    .byp_data(commit_data),
    .rdata   (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) mem_v_q <= 1'b0;
    else     mem_v_q <= rd_fire;
  end

  // ---------------- read latency pipeline ----------------
  // The memory read register is the first stage; lat_c-1 more stages follow.
  generate
    if (lat_c == 1) begin : g_lat1
      assign sram_dat_rd = mem_rdata;
      assign rd_drive    = mem_v_q;
    end else begin : g_latn
      logic [dw-1:0]      sh_d [lat_c-1];
      logic [lat_c-2:0]   sh_v;

      always_ff @(posedge clk) begin
        if (rst) begin
          sh_v <= '0;
          for (int i = 0; i < lat_c - 1; i++) sh_d[i] <= '0;
        end else begin
          sh_v[0] <= mem_v_q;
          sh_d[0] <= mem_rdata;
          for (int i = 1; i < lat_c - 1; i++) begin
            sh_v[i] <= sh_v[i-1];
            sh_d[i] <= sh_d[i-1];
          end
        end
      end

      assign sram_dat_rd = sh_d[lat_c-2];
      assign rd_drive    = sh_v[lat_c-2];
    end
  endgenerate

  // ---------------- access statistics ----------------
`ifdef SRAM_RESPONDER_STATS_EN
  logic [CNT_W-1:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_fire && rd_cnt_q != {CNT_W{1'b1}}) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      if (wr_fire && wr_cnt_q != {CNT_W{1'b1}}) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - scoreboard bench for sram_responder (three timing variants on one bus)
module tb_sram_responder;

  localparam int          AW   = 4;
  localparam int          N    = 3;
  localparam logic [7:0]  FILL = 8'hA5;

  typedef struct {
    logic [7:0]  d;
    int unsigned due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce_n = 1'b1, oe_n = 1'b1, we_n = 1'b1;
  logic [3:0] addr = '0;
  logic [7:0] dat_wr = '0;

  logic [7:0] dat_rd [N];
  logic       drv    [N];
  logic       rdy    [N];
  logic       err    [N];
`ifdef SRAM_RESPONDER_STATS_EN
  logic [31:0] rd_cnt [N];
  logic [31:0] wr_cnt [N];
`endif

  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          mon_en = 0;
  bit          live = 0;
  int          exp_wr = 0;
  int          exp_rd = 0;
  logic [7:0]  mdl [16];
  exp_t        exp_q [N][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // u0: latency 1, wr_lag 1   u1: latency 3, wr_lag 1   u2: latency 2, wr_lag 0
  sram_responder #(.aw(AW), .dw(8), .latency(1), .wr_lag(1), .fill(FILL)) u0 (
    .clk(clk), .rst(rst), .sram_addr(addr), .sram_ce_n(ce_n), .sram_oe_n(oe_n),
    .sram_we_n(we_n), .sram_dat_wr(dat_wr), .sram_dat_rd(dat_rd[0]), .rd_drive(drv[0]),
    .ready(rdy[0]), .err_early(err[0])
`ifdef SRAM_RESPONDER_STATS_EN
    , .rd_count(rd_cnt[0]), .wr_count(wr_cnt[0])
`endif
  );

  sram_responder #(.aw(AW), .dw(8), .latency(3), .wr_lag(1), .fill(FILL)) u1 (
    .clk(clk), .rst(rst), .sram_addr(addr), .sram_ce_n(ce_n), .sram_oe_n(oe_n),
    .sram_we_n(we_n), .sram_dat_wr(dat_wr), .sram_dat_rd(dat_rd[1]), .rd_drive(drv[1]),
    .ready(rdy[1]), .err_early(err[1])
`ifdef SRAM_RESPONDER_STATS_EN
    , .rd_count(rd_cnt[1]), .wr_count(wr_cnt[1])
`endif
  );

  sram_responder #(.aw(AW), .dw(8), .latency(2), .wr_lag(0), .fill(FILL)) u2 (
    .clk(clk), .rst(rst), .sram_addr(addr), .sram_ce_n(ce_n), .sram_oe_n(oe_n),
    .sram_we_n(we_n), .sram_dat_wr(dat_wr), .sram_dat_rd(dat_rd[2]), .rd_drive(drv[2]),
    .ready(rdy[2]), .err_early(err[2])
`ifdef SRAM_RESPONDER_STATS_EN
    , .rd_count(rd_cnt[2]), .wr_count(wr_cnt[2])
`endif
  );

  function automatic int unsigned lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic mon(input int k);
    exp_t e;
    if (drv[k] === 1'b1) begin
      if (exp_q[k].size() == 0) begin
        chk($sformatf("u%0d_unexpected_drive", k), 32'd1, 32'd0);
      end else begin
        e = exp_q[k].pop_front();
        chk($sformatf("u%0d_rd_data", k), 32'(dat_rd[k]), 32'(e.d));
        chk($sformatf("u%0d_rd_cycle", k), cyc, e.due);
      end
    end else begin
      if (exp_q[k].size() != 0 && exp_q[k][0].due <= cyc) begin
        e = exp_q[k].pop_front();
        chk($sformatf("u%0d_rd_drive_missing", k), 32'(drv[k]), 32'd1);
      end
      chk($sformatf("u%0d_idle_data_zero", k), 32'(dat_rd[k]), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) for (int k = 0; k < N; k++) mon(k);
  end

  // ---------------- bus tasks (one bus cycle each) ----------------
  task automatic bus(input logic ce, input logic we, input logic oe,
                     input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    ce_n = ce; we_n = we; oe_n = oe; addr = a;
    if (!ce && !we) dat_wr = d;
  endtask

  task automatic idle();
    bus(1'b1, 1'b1, 1'b1, 4'd0, 8'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus(1'b0, 1'b0, 1'b1, a, d);
    if (live) begin
      mdl[a] = d;
      exp_wr++;
    end
  endtask

  task automatic rd(input logic [3:0] a);
    bus(1'b0, 1'b1, 1'b0, a, 8'd0);
    if (live) begin
      exp_rd++;
      for (int k = 0; k < N; k++) exp_q[k].push_back('{d: mdl[a], due: cyc + lat_of(k)});
    end
  endtask

  task automatic wait_ready(input int unsigned c0, input string name);
    int unsigned waited;
    waited = 0;
    while (rdy[0] !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    chk(name, cyc - c0, 32'd16);
    for (int k = 0; k < N; k++) chk($sformatf("u%0d_ready_high", k), 32'(rdy[k]), 32'd1);
    live = 1;
  endtask

  task automatic fill_model();
    for (int i = 0; i < 16; i++) mdl[i] = FILL;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned c0;
    fill_model();

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("u%0d_rst_dat_rd", k), 32'(dat_rd[k]), 32'd0);
      chk($sformatf("u%0d_rst_rd_drive", k), 32'(drv[k]), 32'd0);
      chk($sformatf("u%0d_rst_ready", k), 32'(rdy[k]), 32'd0);
      chk($sformatf("u%0d_rst_err_early", k), 32'(err[k]), 32'd0);
`ifdef SRAM_RESPONDER_STATS_EN
      chk($sformatf("u%0d_rst_rd_count", k), rd_cnt[k], 32'd0);
      chk($sformatf("u%0d_rst_wr_count", k), wr_cnt[k], 32'd0);
`endif
    end
    mon_en = 1;

    // clear with early accesses in the middle
    rst = 1'b0;
    c0 = cyc;
    repeat (8) idle();
    bus(1'b0, 1'b0, 1'b1, 4'd3, 8'h11);
    bus(1'b0, 1'b1, 1'b0, 4'd4, 8'h00);
    idle();
    for (int k = 0; k < N; k++) chk($sformatf("u%0d_err_early_set", k), 32'(err[k]), 32'd1);
    wait_ready(c0, "ready_delay_first");

    // whole memory holds fill (early write ignored)
    for (int a = 0; a < 16; a++) rd(4'(a));
    idle();
    for (int k = 0; k < N; k++) chk($sformatf("u%0d_err_early_sticky", k), 32'(err[k]), 32'd1);

    // write then read: forwarding, then memory path
    wr(4'd5, 8'h3C); rd(4'd5); idle(); rd(4'd5);
    wr(4'd6, 8'h5A); idle(); rd(4'd6);

    // distinct words for the back-to-back read burst
    wr(4'd1, 8'h11); idle(); wr(4'd2, 8'h22); idle(); wr(4'd3, 8'h33);
    rd(4'd1); rd(4'd2); rd(4'd3);
    idle(); idle(); idle();
    bus(1'b0, 1'b1, 1'b1, 4'd7, 8'h00);
    wr(4'd15, 8'hF0); rd(4'd15); rd(4'd14);
    repeat (6) idle();

    // reset clears err_early and restarts the clear
    rst = 1'b1; live = 0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("u%0d_err_early_cleared", k), 32'(err[k]), 32'd0);
      chk($sformatf("u%0d_ready_cleared", k), 32'(rdy[k]), 32'd0);
    end
    rst = 1'b0;
    c0 = cyc;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    c0 = cyc;
    fill_model();
    wait_ready(c0, "ready_delay_midclear");
    for (int a = 0; a < 16; a++) rd(4'(a));
    repeat (6) idle();

`ifdef SRAM_RESPONDER_STATS_EN
    rst = 1'b1; live = 0;
    @(negedge clk);
    rst = 1'b0;
    c0 = cyc;
    fill_model();
    exp_wr = 0; exp_rd = 0;
    wait_ready(c0, "ready_delay_stats");
    wr(4'd0, 8'h01); idle(); wr(4'd1, 8'h02); idle(); wr(4'd2, 8'h03); idle(); wr(4'd3, 8'h04);
    for (int a = 0; a < 6; a++) rd(4'(a));
    bus(1'b0, 1'b1, 1'b1, 4'd0, 8'h00);
    bus(1'b0, 1'b1, 1'b1, 4'd1, 8'h00);
    idle();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("u%0d_wr_count", k), wr_cnt[k], 32'd4);
      chk($sformatf("u%0d_rd_count", k), rd_cnt[k], 32'd6);
    end
    force u0.rd_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release u0.rd_cnt_q;
    rd(4'd0);
    idle();
    chk("u0_rd_count_saturated", rd_cnt[0], 32'hFFFF_FFFF);
    repeat (6) idle();
`endif

    for (int k = 0; k < N; k++)
      chk($sformatf("u%0d_queue_drained", k), 32'(exp_q[k].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
